// File: rtl/wash_seq_if.sv
// Switch/sensor inputs and actuator/LED outputs of the wash-programme sequencer.
// The master side drives the debounced inputs; the sequencer is the slave.
interface wash_seq_if;
    logic       start;
    logic       pause;
    logic       abort;
    logic       full;
    logic       empty;
    logic       cold;
    logic       ready;
    logic       water_in;
    logic       wash;
    logic       drain;
    logic       speed;
    logic       heat_r;
    logic       fault;
    logic [2:0] rinse_idx;

    modport master (
        output start, pause, abort, full, empty, cold,
        input  ready, water_in, wash, drain, speed, heat_r, fault, rinse_idx
    );

    modport slave (
        input  start, pause, abort, full, empty, cold,
        output ready, water_in, wash, drain, speed, heat_r, fault, rinse_idx
    );
endinterface

// File: rtl/wash_seq.sv
// Wash-programme sequencer: fill/wash/drain/spin, then N_RINSE rinse cycles,
// with pause, forced-drain abort and fill/drain watchdogs.
module wash_seq #(
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned WASH_TICKS    = 200000000,
    parameter int unsigned RINSE_TICKS   = 100000000,
    parameter int unsigned SPIN_TICKS    = 100000000,
    parameter int unsigned FILL_TIMEOUT  = 250000000,
    parameter int unsigned DRAIN_TIMEOUT = 250000000,
    parameter int unsigned N_RINSE       = 2
) (
    input  logic       clk,
    input  logic       reset,
    wash_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_WASH,
        S_RINSE,
        S_DRAIN,
        S_SPIN,
        S_ABORT_DRAIN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [2:0]       LAST_CYC   = 3'(N_RINSE);

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [2:0]       cyc, cyc_n;
    logic             active;
    logic             paused;

    // abort and pause only act while a programme is actually running
    assign active = (state == S_FILL) || (state == S_WASH) || (state == S_RINSE) ||
                    (state == S_DRAIN) || (state == S_SPIN);
    assign paused = active && bus.pause;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
            cyc   <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            cyc   <= cyc_n;
        end
    end

    always_comb begin
        state_n = state;
        cyc_n   = cyc;
        timer_n = timer + CNT_W'(1);
        if (active && bus.abort) begin
            state_n = S_ABORT_DRAIN;
        end else if (paused) begin
            timer_n = timer;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_n = S_FILL;
                        cyc_n   = '0;
                    end
                end
                S_FILL: begin
                    if (bus.full)
                        state_n = (cyc == '0) ? S_WASH : S_RINSE;
                    else if (timer == FILL_LAST)
                        state_n = S_FAULT;
                end
                S_WASH:  if (timer == WASH_LAST)  state_n = S_DRAIN;
                S_RINSE: if (timer == RINSE_LAST) state_n = S_DRAIN;
                S_DRAIN: begin
                    if (bus.empty)
                        state_n = S_SPIN;
                    else if (timer == DRAIN_LAST)
                        state_n = S_FAULT;
                end
                S_SPIN: begin
                    if (timer == SPIN_LAST) begin
                        if (cyc == LAST_CYC) begin
                            state_n = S_IDLE;
                        end else begin
                            cyc_n   = cyc + 3'd1;
                            state_n = S_FILL;
                        end
                    end
                end
                S_ABORT_DRAIN: if (bus.empty) state_n = S_IDLE;
                S_FAULT: ;
                default: state_n = S_IDLE;
            endcase
        end
        // IDLE always reports cycle 0, including after an abort
        if (state_n == S_IDLE)
            cyc_n = '0;
        if (state_n != state)
            timer_n = '0;
    end

    always_comb begin
        bus.ready     = (state == S_IDLE);
        bus.fault     = (state == S_FAULT);
        bus.rinse_idx = cyc;
        bus.water_in  = 1'b0;
        bus.wash      = 1'b0;
        bus.drain     = 1'b0;
        bus.speed     = 1'b0;
        bus.heat_r    = 1'b0;
        if (!paused) begin
            unique case (state)
                S_FILL:  bus.water_in = 1'b1;
                S_WASH: begin
                    bus.wash   = 1'b1;
                    bus.heat_r = bus.cold;
                end
                S_RINSE: bus.wash = 1'b1;
                S_DRAIN, S_ABORT_DRAIN: bus.drain = 1'b1;
                S_SPIN: begin
                    bus.drain = 1'b1;
                    bus.speed = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/wash_seq.md
# wash_seq

Parametrised wash-programme sequencer for the Basys 2 washing-machine controller; successor to the single-cycle wash state machine. Runs a fill/wash/drain/spin cycle followed by N_RINSE rinse cycles, with cycle-exact timed phases, pause and abort handling, and fill/drain watchdogs. It sits between the debounced switch inputs (start, pause, abort, level sensors) and the actuator/LED outputs.

## Interface
- CNT_W, 28: phase timer width; must satisfy 2^CNT_W > every *_TICKS/*_TIMEOUT value
- WASH_TICKS, 200000000: clk cycles spent in WASH (4 s at 50 MHz)
- RINSE_TICKS, 100000000: clk cycles spent agitating in RINSE
- SPIN_TICKS, 100000000: clk cycles spent in SPIN
- FILL_TIMEOUT, 250000000: max cycles in FILL before fault
- DRAIN_TIMEOUT, 250000000: max cycles in DRAIN before fault
- N_RINSE, 2: rinse cycles after the wash cycle (0..7)
- clk  in  1  system clock, 50 MHz, rising edge
- reset  in  1  asynchronous, active-high; state and all counters cleared on assertion
- start  in  1  level; begins a programme from IDLE
- pause  in  1  level; freezes the programme while high
- abort  in  1  level; ends the programme via a forced drain
- full  in  1  drum full level sensor
- empty  in  1  drum empty level sensor
- cold  in  1  water below temperature
- ready  out  1  high in IDLE only
- water_in  out  1  fill valve
- wash  out  1  agitate motor (WASH and RINSE)
- drain  out  1  drain pump
- speed  out  1  spin motor
- heat_r  out  1  heater relay
- fault  out  1  high in FAULT
- rinse_idx  out  3  current cycle: 0 = wash cycle, 1..N_RINSE = rinse cycle

## Operation
- States: IDLE, FILL, WASH, RINSE, DRAIN, SPIN, ABORT_DRAIN, FAULT. Registered state, timer[CNT_W-1:0], cyc[2:0].
- Timer clears to 0 on every state change; otherwise increments each unpaused cycle.
- IDLE: start=1 -> FILL, cyc=0.
- FILL: full=1 -> WASH if cyc==0, else RINSE. full=0 and timer==FILL_TIMEOUT-1 -> FAULT. full wins if both occur in the same cycle.
- WASH: timer==WASH_TICKS-1 -> DRAIN. RINSE: timer==RINSE_TICKS-1 -> DRAIN.
- DRAIN: empty=1 -> SPIN; empty=0 and timer==DRAIN_TIMEOUT-1 -> FAULT; empty wins.
- SPIN: timer==SPIN_TICKS-1 -> if cyc==N_RINSE then IDLE, else cyc+1 and FILL.
- abort=1 in any of FILL/WASH/RINSE/DRAIN/SPIN -> ABORT_DRAIN (also while paused). ABORT_DRAIN: drain=1 until empty=1 -> IDLE; no watchdog. abort is ignored in IDLE, FAULT and ABORT_DRAIN.
- pause=1 (no abort) in FILL..SPIN: state, timer and cyc hold; all actuator outputs 0; watchdogs frozen.
- FAULT: all actuators 0, fault=1; exits only on reset.
- Outputs are Moore-decoded from the state, gated by pause: FILL water_in; WASH wash, plus heat_r=cold; RINSE wash (no heat); DRAIN and ABORT_DRAIN drain; SPIN drain and speed. At most one state's outputs are active at a time.
- rinse_idx = cyc in every state; 0 in IDLE.

## Timing
- Reset values: state IDLE, timer 0, cyc 0; ready=1, fault=0, rinse_idx=0, all other outputs 0.
- Inputs are sampled on the rising clk edge; a state change is visible on the outputs the cycle after the triggering sample (1-cycle latency).
- Exactly WASH_TICKS / RINSE_TICKS / SPIN_TICKS unpaused cycles are spent in each timed state; paused cycles are not counted.
- Fault is raised after exactly FILL_TIMEOUT (or DRAIN_TIMEOUT) unpaused cycles in FILL (or DRAIN) without the sensor.
- Priority each cycle: reset > abort > pause > normal transition.
- Reset mid-programme: immediate return to IDLE outputs, asynchronously, without waiting for a clk edge.
- N_RINSE=0: SPIN after wash returns directly to IDLE.

## Test plan
Bench parameters: WASH_TICKS=8, RINSE_TICKS=4, SPIN_TICKS=3, FILL_TIMEOUT=16, DRAIN_TIMEOUT=16, N_RINSE=2.
- Full programme: start pulse, full asserted 2 cycles into each FILL, empty asserted 1 cycle into each DRAIN -> sequence FILL,WASH(8),DRAIN,SPIN(3) with rinse_idx 0, then two rinse cycles with RINSE(4) and rinse_idx 1,2 -> IDLE, ready=1.
- Heat: cold=1 during WASH -> heat_r=1 for all 8 WASH cycles; cold=1 during RINSE -> heat_r=0.
- Pause: pause=1 for 5 cycles at WASH timer=3 -> outputs 0 while paused; WASH lasts 8+5 cycles in total, then DRAIN.
- Abort: abort in RINSE (rinse_idx=1) -> ABORT_DRAIN with drain=1 only; empty=1 -> IDLE, rinse_idx=0.
- Watchdog: full held 0 in FILL -> fault=1 after 16 cycles, all actuators 0; start ignored; reset -> IDLE. Check also that full asserted on the timeout cycle leads to WASH, not FAULT.
- Async reset during SPIN between clk edges -> outputs return to reset values immediately.
